// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches into byte accesses on the
// external RAM/IO bus. LSB requests win over fetch; each request ends with a one-cycle valid pulse.
module mem_ctrl #(
   parameter int         ADDR_W     = 32,
   parameter logic [1:0] IO_MASK_HI = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              lsb_enable,
   input  logic              lsb_wr,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [31:0]       lsb_din,
   input  logic [2:0]        lsb_len,
   output logic              lsb_valid,
   output logic [31:0]       lsb_dout,
   input  logic              if_enable,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [31:0]       if_dout,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LSB_RD = 3'd1,
      ST_LSB_WR = 3'd2,
      ST_IF_RD  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr, r_mem_a, w_addr_nxt;
   logic [31:0]       r_rdata, w_merged, r_lsb_dout, r_if_dout;
   logic [23:0]       r_wdata;
   logic [7:0]        r_mem_dout;
   logic [2:0]        r_cnt, r_n, w_cnt_inc, w_len_n;
   logic              r_is_if, r_mem_wr, r_lsb_valid, r_if_valid;
   logic              w_stall, w_rd_last, w_wr_last;

   assign w_len_n    = ((lsb_len >= 3'd1) && (lsb_len <= 3'd4)) ? lsb_len : 3'd4;
   assign w_cnt_inc  = r_cnt + 3'd1;
   assign w_addr_nxt = r_addr + ADDR_W'(w_cnt_inc);
   assign w_rd_last  = (r_cnt == r_n);
   assign w_wr_last  = (w_cnt_inc == r_n);
   assign w_stall    = (r_state == ST_LSB_WR) && (r_addr[17:16] == IO_MASK_HI) && io_buffer_full;

   // mem_wr is the registered write intent, withheld in the same cycle by an I/O stall or rdy low.
   assign mem_wr    = r_mem_wr & rdy & ~w_stall;
   assign mem_a     = r_mem_a;
   assign mem_dout  = r_mem_dout;
   assign lsb_valid = r_lsb_valid;
   assign lsb_dout  = r_lsb_dout;
   assign if_valid  = r_if_valid & ~rollback;
   assign if_dout   = r_if_dout;

   // mem_din carries the byte addressed in the previous cycle, i.e. byte index r_cnt-1.
   always_comb begin
      w_merged = r_rdata;
      case (r_cnt)
         3'd1:    w_merged[7:0]   = mem_din;
         3'd2:    w_merged[15:8]  = mem_din;
         3'd3:    w_merged[23:16] = mem_din;
         3'd4:    w_merged[31:24] = mem_din;
         default: w_merged        = r_rdata;
      endcase
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      if (!rdy) begin
         w_next = r_state;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (lsb_enable) begin
                  w_next = lsb_wr ? ST_LSB_WR : ST_LSB_RD;
               end else if (if_enable) begin
                  w_next = ST_IF_RD;
               end else begin
                  w_next = ST_IDLE;
               end
            end
            ST_LSB_RD: w_next = w_rd_last ? ST_DONE : ST_LSB_RD;
            ST_LSB_WR: w_next = (!w_stall && w_wr_last) ? ST_DONE : ST_LSB_WR;
            ST_IF_RD: begin
               if (rollback) begin
                  w_next = ST_IDLE;
               end else begin
                  w_next = w_rd_last ? ST_DONE : ST_IF_RD;
               end
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request latching, byte sequencing and registered outputs; all frozen while rdy is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_mem_a     <= '0;
         r_rdata     <= 32'h0;
         r_wdata     <= 24'h0;
         r_lsb_dout  <= 32'h0;
         r_if_dout   <= 32'h0;
         r_mem_dout  <= 8'h00;
         r_cnt       <= 3'd0;
         r_n         <= 3'd0;
         r_is_if     <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_lsb_valid <= 1'b0;
         r_if_valid  <= 1'b0;
      end else if (rdy) begin
         r_lsb_valid <= 1'b0;
         r_if_valid  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (lsb_enable) begin
                  r_addr     <= lsb_addr;
                  r_mem_a    <= lsb_addr;
                  r_n        <= w_len_n;
                  r_is_if    <= 1'b0;
                  r_wdata    <= lsb_din[31:8];
                  r_mem_dout <= lsb_din[7:0];
                  r_mem_wr   <= lsb_wr;
                  r_cnt      <= 3'd0;
                  r_rdata    <= 32'h0;
               end else if (if_enable) begin
                  r_addr   <= if_addr;
                  r_mem_a  <= if_addr;
                  r_n      <= 3'd4;
                  r_is_if  <= 1'b1;
                  r_mem_wr <= 1'b0;
                  r_cnt    <= 3'd0;
                  r_rdata  <= 32'h0;
               end
            end
            ST_LSB_RD, ST_IF_RD: begin
               if ((r_state == ST_IF_RD) && rollback) begin
                  r_cnt <= 3'd0;
               end else begin
                  r_cnt   <= w_cnt_inc;
                  r_rdata <= w_merged;
                  r_mem_a <= w_addr_nxt;
                  if (w_rd_last) begin
                     if (r_is_if) begin
                        r_if_valid <= 1'b1;
                        r_if_dout  <= w_merged;
                     end else begin
                        r_lsb_valid <= 1'b1;
                        r_lsb_dout  <= w_merged;
                     end
                  end
               end
            end
            ST_LSB_WR: begin
               if (!w_stall) begin
                  r_cnt      <= w_cnt_inc;
                  r_mem_a    <= w_addr_nxt;
                  r_mem_dout <= r_wdata[7:0];
                  r_wdata    <= {8'h00, r_wdata[23:8]};
                  if (w_wr_last) begin
                     r_mem_wr    <= 1'b0;
                     r_lsb_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model answers one cycle after each address and
// pauses with rdy; every check is an immediate assertion against a hand-computed value.
module tb_mem_ctrl;
   logic        clk, rst, rdy, rollback, lsb_enable, lsb_wr, if_enable, io_buffer_full;
   logic [31:0] lsb_addr, lsb_din, if_addr, lsb_dout, if_dout, mem_a;
   logic [2:0]  lsb_len;
   logic        lsb_valid, if_valid, mem_wr;
   logic [7:0]  mem_din, mem_dout;
   logic [7:0]  ram [0:1023];
   int          n_chk = 0;
   int          n_fail = 0;

   mem_ctrl #(.ADDR_W(32), .IO_MASK_HI(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_din(lsb_din),
      .lsb_len(lsb_len), .lsb_valid(lsb_valid), .lsb_dout(lsb_dout),
      .if_enable(if_enable), .if_addr(if_addr), .if_valid(if_valid), .if_dout(if_dout),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: preloaded while reset is low, one-cycle read latency, paused by rdy.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
         ram[10'h100] <= 8'h11; ram[10'h101] <= 8'h22;
         ram[10'h102] <= 8'h33; ram[10'h103] <= 8'h44;
         ram[10'h200] <= 8'hFF; ram[10'h201] <= 8'h80;
         ram[10'h300] <= 8'hDE; ram[10'h301] <= 8'hAD;
         ram[10'h302] <= 8'hBE; ram[10'h303] <= 8'hEF;
      end else begin
         if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
         if (rdy) mem_din <= ram[mem_a[9:0]];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'h0; lsb_din = 32'h0; lsb_len = 3'd0;
      if_enable = 1'b0; if_addr = 32'h0;
      #12;
      chk("rst_lsb_valid", 32'(lsb_valid), 32'd0);
      chk("rst_if_valid",  32'(if_valid),  32'd0);
      chk("rst_lsb_dout",  lsb_dout,       32'h0);
      chk("rst_if_dout",   if_dout,        32'h0);
      chk("rst_mem_a",     mem_a,          32'h0);
      chk("rst_mem_wr",    32'(mem_wr),    32'd0);
      chk("rst_mem_dout",  32'(mem_dout),  32'd0);
      rst = 1'b1;
      step();

      // LW 0x100: addresses cycles 1-4, valid cycle 6
      step(); lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("lw_addr", mem_a, 32'h100 + 32'(k));
         chk("lw_rd", 32'(mem_wr), 32'd0);
      end
      step(); chk("lw_early", 32'(lsb_valid), 32'd0);
      step(); chk("lw_valid", 32'(lsb_valid), 32'd1); chk("lw_data", lsb_dout, 32'h44332211);
      step(); lsb_enable = 1'b0; chk("lw_pulse", 32'(lsb_valid), 32'd0);

      // SB to I/O region with the output buffer full in cycles 1-3
      step(); lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_din = 32'hA5;
      lsb_len = 3'd1; io_buffer_full = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(); #1;
         chk("sb_stall_wr", 32'(mem_wr), 32'd0);
         chk("sb_stall_a", mem_a, 32'h30000);
      end
      step(); io_buffer_full = 1'b0; #1;
      chk("sb_wr", 32'(mem_wr), 32'd1); chk("sb_dout", 32'(mem_dout), 32'hA5);
      chk("sb_early", 32'(lsb_valid), 32'd0);
      step(); chk("sb_valid", 32'(lsb_valid), 32'd1); chk("sb_wr_off", 32'(mem_wr), 32'd0);
      step(); lsb_enable = 1'b0; lsb_wr = 1'b0; chk("sb_pulse", 32'(lsb_valid), 32'd0);

      // LH 0x200, enable held through the valid cycle
      step(); lsb_enable = 1'b1; lsb_addr = 32'h200; lsb_len = 3'd2;
      step(); step(); step(); chk("lh_early", 32'(lsb_valid), 32'd0);
      step(); chk("lh_valid", 32'(lsb_valid), 32'd1); chk("lh_data", lsb_dout, 32'h000080FF);
      step(); lsb_enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step(); chk("lh_once", 32'(lsb_valid), 32'd0);
      end

      // Length 3 and out-of-range length 7 (treated as 4)
      step(); lsb_enable = 1'b1; lsb_addr = 32'h100; lsb_len = 3'd3;
      for (int k = 0; k < 4; k++) step();
      chk("len3_early", 32'(lsb_valid), 32'd0);
      step(); chk("len3_valid", 32'(lsb_valid), 32'd1); chk("len3_data", lsb_dout, 32'h00332211);
      step(); lsb_enable = 1'b0;
      step(); lsb_enable = 1'b1; lsb_len = 3'd7;
      for (int k = 0; k < 5; k++) step();
      chk("len7_early", 32'(lsb_valid), 32'd0);
      step(); chk("len7_valid", 32'(lsb_valid), 32'd1); chk("len7_data", lsb_dout, 32'h44332211);
      step(); lsb_enable = 1'b0;

      // LSB and fetch together: LSB first, fetch accepted in the IDLE after DONE
      step(); lsb_enable = 1'b1; lsb_addr = 32'h100; lsb_len = 3'd1;
      if_enable = 1'b1; if_addr = 32'h300;
      step(); chk("both_lsb_first", mem_a, 32'h100);
      step();
      step(); chk("both_lsb_valid", 32'(lsb_valid), 32'd1); chk("both_lsb_data", lsb_dout, 32'h11);
      chk("both_if_wait", 32'(if_valid), 32'd0);
      step(); lsb_enable = 1'b0;
      step(); chk("both_if_addr", mem_a, 32'h300); chk("both_lsb_once", 32'(lsb_valid), 32'd0);
      for (int k = 0; k < 4; k++) step();
      chk("both_if_early", 32'(if_valid), 32'd0);
      step(); chk("both_if_valid", 32'(if_valid), 32'd1); chk("both_if_data", if_dout, 32'hEFBEADDE);
      step(); if_enable = 1'b0; chk("both_if_pulse", 32'(if_valid), 32'd0);

      // Rollback in cycle 3 of a fetch: IDLE next cycle, no if_valid
      step(); if_enable = 1'b1; if_addr = 32'h300;
      step(); step();
      step(); rollback = 1'b1; if_enable = 1'b0;
      step(); rollback = 1'b0; lsb_enable = 1'b1; lsb_addr = 32'h101; lsb_len = 3'd1; #1;
      chk("rb_if_c4", 32'(if_valid), 32'd0);
      step(); chk("rb_idle", mem_a, 32'h101); chk("rb_if_c5", 32'(if_valid), 32'd0);
      step(); chk("rb_if_c6", 32'(if_valid), 32'd0);
      step(); chk("rb_lsb_valid", 32'(lsb_valid), 32'd1); chk("rb_lsb_data", lsb_dout, 32'h22);
      step(); lsb_enable = 1'b0;

      // Rollback in cycle 3 of an LSB read has no effect
      step(); lsb_enable = 1'b1; lsb_addr = 32'h100; lsb_len = 3'd4;
      step(); step();
      step(); rollback = 1'b1;
      step(); rollback = 1'b0;
      step(); chk("rbl_early", 32'(lsb_valid), 32'd0);
      step(); chk("rbl_valid", 32'(lsb_valid), 32'd1); chk("rbl_data", lsb_dout, 32'h44332211);
      step(); lsb_enable = 1'b0;

      // rdy low in cycles 3-4 of a word read: valid moves from cycle 6 to cycle 8
      step(); lsb_enable = 1'b1; lsb_addr = 32'h100; lsb_len = 3'd4;
      step(); step();
      step(); rdy = 1'b0; #1; chk("rdy_wr", 32'(mem_wr), 32'd0);
      step();
      step(); rdy = 1'b1;
      step(); chk("rdy_c6", 32'(lsb_valid), 32'd0);
      step(); chk("rdy_c7", 32'(lsb_valid), 32'd0);
      step(); chk("rdy_valid", 32'(lsb_valid), 32'd1); chk("rdy_data", lsb_dout, 32'h44332211);
      step(); lsb_enable = 1'b0;

      // Reset asserted while byte 2 of a word store is on the bus
      step(); lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h10; lsb_din = 32'h87654321;
      lsb_len = 3'd4;
      step(); chk("sw_b0", 32'(mem_dout), 32'h21);
      step();
      step();
      chk("sw_b2_a", mem_a, 32'h12); chk("sw_b2_d", 32'(mem_dout), 32'h65);
      chk("sw_b2_wr", 32'(mem_wr), 32'd1);
      chk("sw_ram0", 32'(ram[16]), 32'h21); chk("sw_ram1", 32'(ram[17]), 32'h43);
      #1 rst = 1'b0; lsb_enable = 1'b0; lsb_wr = 1'b0; #1;
      chk("rstw_mem_a", mem_a, 32'h0);
      chk("rstw_mem_wr", 32'(mem_wr), 32'd0);
      chk("rstw_mem_dout", 32'(mem_dout), 32'd0);
      chk("rstw_lsb_valid", 32'(lsb_valid), 32'd0);
      chk("rstw_lsb_dout", lsb_dout, 32'h0);
      chk("rstw_if_dout", if_dout, 32'h0);
      chk("rstw_if_valid", 32'(if_valid), 32'd0);
      step(); rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("sw_dropped", 32'(lsb_valid), 32'd0);
         chk("sw_idle_wr", 32'(mem_wr), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
